// File: rtl/nn_pkg.sv
// Shared definitions for the inference datapath stages.
// Score format, default widths and the argmax state encoding.
package nn_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_IDX_W  = 4;

    // Scores are Q3.13 signed fixed point.
    localparam int FRAC_BITS = 13;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        HOLD = 3'b100
    } argmax_state_t;

endpackage

// File: rtl/signed_max_cmp.sv
// Combinational signed max select between a candidate and the running best.
// Strict greater-than: on a tie the existing best is kept.
module signed_max_cmp
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic signed [DATA_W-1:0] cand_val,
    input  logic        [IDX_W-1:0]  cand_idx,
    input  logic signed [DATA_W-1:0] best_val,
    input  logic        [IDX_W-1:0]  best_idx,
    output logic signed [DATA_W-1:0] new_val,
    output logic        [IDX_W-1:0]  new_idx
);

    logic take;

    assign take    = cand_val > best_val;
    assign new_val = take ? cand_val : best_val;
    assign new_idx = take ? cand_idx : best_idx;

endmodule

// File: rtl/argmax_classifier.sv
// Argmax over one frame of signed class scores; emits the winning index.
// Optional ARGMAX_SCORE_OUT_EN adds m_tscore carrying the winning score.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int MAX_CLASS = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic signed [DATA_W-1:0] s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic        [IDX_W-1:0]  m_tdata,
`ifdef ARGMAX_SCORE_OUT_EN
    output logic signed [DATA_W-1:0] m_tscore,
`endif
    input  logic        [IDX_W-1:0]  class_num,
    output logic        [15:0]       frame_cnt
);

    // lim must be able to hold MAX_CLASS, which can equal 2**IDX_W.
    localparam int               LIM_W   = IDX_W + 1;
    localparam logic [LIM_W-1:0] LIM_MAX = LIM_W'(MAX_CLASS);
    localparam logic [LIM_W-1:0] LIM_ONE = LIM_W'(1);

    argmax_state_t state, next_state;

    logic signed [DATA_W-1:0] best_val;
    logic        [IDX_W-1:0]  best_idx;
    logic        [IDX_W-1:0]  beat_idx;
    logic        [LIM_W-1:0]  lim;
    logic        [LIM_W-1:0]  first_lim;
    logic        [LIM_W-1:0]  cn_ext;
    logic signed [DATA_W-1:0] cmp_val;
    logic        [IDX_W-1:0]  cmp_idx;
    logic                     accept;
    logic                     last_beat;

    signed_max_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .cand_val (s_tdata),
        .cand_idx (beat_idx),
        .best_val (best_val),
        .best_idx (best_idx),
        .new_val  (cmp_val),
        .new_idx  (cmp_idx)
    );

    assign accept    = s_tvalid && s_tready;
    assign last_beat = {1'b0, beat_idx} == (lim - LIM_ONE);
    assign cn_ext    = {1'b0, class_num};

    // Frame length for a frame starting now: zero means one, clamp to MAX_CLASS.
    always_comb begin
        first_lim = cn_ext;
        if (cn_ext == '0) begin
            first_lim = LIM_ONE;
        end else if (cn_ext > LIM_MAX) begin
            first_lim = LIM_MAX;
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        s_tready   = 1'b1;
        m_tvalid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (first_lim == LIM_ONE) ? HOLD : SCAN;
                end
            end
            SCAN: begin
                if (accept && last_beat) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                s_tready = 1'b0;
                m_tvalid = 1'b1;
                if (m_tready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Running best score, best index, beat position and latched frame length.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            best_val <= '0;
            best_idx <= '0;
            beat_idx <= '0;
            lim      <= LIM_ONE;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    best_val <= s_tdata;
                    best_idx <= '0;
                    beat_idx <= IDX_W'(1);
                    lim      <= first_lim;
                end
                SCAN: begin
                    best_val <= cmp_val;
                    best_idx <= cmp_idx;
                    beat_idx <= beat_idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Count of results handed to the consumer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
        end else if (state == HOLD && m_tready) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign m_tdata = best_idx;
`ifdef ARGMAX_SCORE_OUT_EN
    assign m_tscore = best_val;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: frame table plus scoreboard.
// Also covers hold-off, class_num resampling and mid-frame reset.
module tb_argmax_classifier;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [3:0]  m_tdata;
    logic [3:0]  class_num;
    logic [15:0] frame_cnt;
`ifdef ARGMAX_SCORE_OUT_EN
    logic [15:0] m_tscore;
`endif

    argmax_classifier dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
`ifdef ARGMAX_SCORE_OUT_EN
        .m_tscore  (m_tscore),
`endif
        .class_num (class_num),
        .frame_cnt (frame_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  cn;
        int          n;
        logic [15:0] b [16];
        logic [3:0]  idx;
        logic [15:0] sc;
        int          hold;
    } vec_t;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] sc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   fcnt_exp = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] cn, input int n,
                                input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3,
                                input logic [3:0] idx, input logic [15:0] sc,
                                input int hold);
        vec_t v;
        for (int i = 0; i < 16; i++) v.b[i] = '0;
        v.cn = cn; v.n = n;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.idx = idx; v.sc = sc; v.hold = hold;
        vecs.push_back(v);
    endfunction

    // Called just after a negedge; returns just after the negedge that
    // follows the last accepted beat.
    task automatic send_frame(input vec_t v, input bit push);
        exp_t e;
        for (int i = 0; i < v.n; i++) begin
            if (s_tready !== 1'b1) begin
                tests++; fails++;
                $display("FAIL s_tready_beat: got %b expected 1", s_tready);
            end
            s_tvalid  = 1'b1;
            s_tdata   = v.b[i];
            class_num = (i == 0) ? v.cn : ~v.cn;
            @(negedge aclk);
        end
        s_tvalid = 1'b0;
        if (push) begin
            check("latency_m_tvalid", 32'(m_tvalid), 32'd1);
            e.idx = v.idx; e.sc = v.sc;
            sb.push_back(e);
        end
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   k;
        k = 0;
        while (m_tvalid !== 1'b1 && k < 20) begin
            @(negedge aclk); k++;
        end
        if (m_tvalid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL result_timeout: got m_tvalid %b expected 1", m_tvalid);
            return;
        end
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: got result %0h expected none", m_tdata);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_m_tdata", 32'(m_tdata), 32'(e.idx));
            check("hold_s_tready", 32'(s_tready), 32'd0);
            @(negedge aclk);
        end
        check("m_tdata", 32'(m_tdata), 32'(e.idx));
`ifdef ARGMAX_SCORE_OUT_EN
        check("m_tscore", 32'(m_tscore), 32'(e.sc));
`endif
        m_tready = 1'b1;
        @(negedge aclk);
        m_tready = 1'b0;
        fcnt_exp++;
        check("frame_cnt", 32'(frame_cnt), 32'(fcnt_exp));
        check("post_s_tready", 32'(s_tready), 32'd1);
        check("post_m_tvalid", 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        add(4'd3, 3, 16'h0100, 16'h0500, 16'h0200, 16'h0000, 4'd1, 16'h0500, 0);
        add(4'd4, 4, 16'hFF00, 16'h8000, 16'hFFF0, 16'hFF80, 4'd2, 16'hFFF0, 0);
        add(4'd3, 3, 16'h0300, 16'h0300, 16'h0100, 16'h0000, 4'd0, 16'h0300, 0);
        add(4'd2, 2, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 4'd1, 16'h0020, 5);
        add(4'd0, 1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'd0, 16'h1234, 0);
        add(4'd1, 1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 16'h8000, 1);
        add(4'd3, 3, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 4'd0, 16'h8000, 0);
        add(4'd2, 2, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 4'd0, 16'h7FFF, 0);
        for (int i = 0; i < 16; i++) v.b[i] = 16'(i * 16);
        v.b[14] = 16'h7000;
        v.cn = 4'd15; v.n = 15; v.idx = 4'd14; v.sc = 16'h7000; v.hold = 2;
        vecs.push_back(v);

        aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        m_tready = 1'b0; class_num = 4'd3;
        #12;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        foreach (vecs[i]) begin
            send_frame(vecs[i], 1'b1);
            collect(vecs[i].hold);
        end

        v = vecs[0];
        v.b[0] = 16'h0100; v.b[1] = 16'h0700;
        v.n = 2;
        send_frame(v, 1'b0);
        aresetn = 1'b0;
        #2;
        check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_s_tready", 32'(s_tready), 32'd1);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        fcnt_exp = 0;
        @(negedge aclk);
        check("midrst_idle_m_tvalid", 32'(m_tvalid), 32'd0);

        v.cn = 4'd3; v.n = 3;
        v.b[0] = 16'h0001; v.b[1] = 16'h0002; v.b[2] = 16'h0003;
        v.idx = 4'd2; v.sc = 16'h0003;
        send_frame(v, 1'b1);
        collect(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
